// File: rtl/upsample_pad_stream_pkg.sv
// -----------------------------------------------------------------------------
// upsample_pad_stream_pkg
//   Shared constants for the zero-insertion upsampler and the trans-conv
//   layers that consume its output.
//   - state_e    : FSM state encoding for the upsampler
//   - out_dim()  : padded, upsampled side length for a square input frame
//   - cnt_width(): width of a position counter that spans 0..n-1
// -----------------------------------------------------------------------------
package upsample_pad_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Side length after zero insertion (x2) and padding on both sides.
  function automatic int out_dim(input int in_width, input int pad_a, input int pad_b);
    return 2 * in_width + pad_a + pad_b;
  endfunction

  // Counter width for values 0..n-1. Never returns 0, so tiny frames still
  // get a legal one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upsample_pad_stream.sv
// -----------------------------------------------------------------------------
// upsample_pad_stream
//   Converts a square raster-order input frame (IN_WIDTH x IN_WIDTH) into a
//   zero-inserted, zero-padded output frame (OUT_WIDTH x OUT_HEIGHT). Every
//   second row and column of the inner 2*IN_WIDTH grid carries an input pixel;
//   all other positions, including the pad border, emit 0.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   valid_in   : upstream pixel valid (held until accepted)
//   data_in    : upstream signed pixel
//   ready_out  : pixel accepted this cycle (decoded from state and position only)
//   valid_out  : data_out holds an output pixel
//   data_out   : signed output pixel, registered (one-cycle latency)
//   frame_done : pulses together with the last output pixel of a frame
// -----------------------------------------------------------------------------
module upsample_pad_stream
  import upsample_pad_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 14,
  parameter int PAD_TOP    = 2,
  parameter int PAD_BOTTOM = 3,
  parameter int PAD_LEFT   = 2,
  parameter int PAD_RIGHT  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         ready_out,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         frame_done
);

  localparam int OUT_WIDTH  = out_dim(IN_WIDTH, PAD_LEFT, PAD_RIGHT);
  localparam int OUT_HEIGHT = out_dim(IN_WIDTH, PAD_TOP, PAD_BOTTOM);
  localparam int COL_W      = cnt_width(OUT_WIDTH);
  localparam int ROW_W      = cnt_width(OUT_HEIGHT);
  localparam int SPAN       = 2 * IN_WIDTH;

  localparam logic [COL_W-1:0] COL_LO   = COL_W'(PAD_LEFT);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(PAD_TOP);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);

  state_e state_q, state_d;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  logic [COL_W-1:0] v_off;
  logic [ROW_W-1:0] u_off;
  logic             data_pos;
  logic             last_pos;
  logic             advance;
  logic             emit;
  logic signed [DATA_WIDTH-1:0] emit_data;

  // Offsets into the inner grid. Positions above/left of the grid wrap to a
  // large unsigned value (counter range covers the pad), so a single
  // "< SPAN" test rejects both sides of the border.
  assign u_off = row_q - ROW_LO;
  assign v_off = col_q - COL_LO;

  assign data_pos = (int'(u_off) < SPAN) && (int'(v_off) < SPAN) &&
                    !u_off[0] && !v_off[0];
  assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    ready_out = 1'b0;
    advance   = 1'b0;
    emit      = 1'b0;
    emit_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Entering RUN only arms the counters; no pixel moves on this edge.
        if (valid_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (data_pos) begin
          // ready_out never looks at valid_in, keeping the handshake free of
          // combinational loops through the upstream block.
          ready_out = 1'b1;
          if (valid_in) begin
            advance   = 1'b1;
            emit      = 1'b1;
            emit_data = data_in;
          end
        end else begin
          advance = 1'b1;
          emit    = 1'b1;
        end
        if (advance && last_pos) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignments so all registers sample the old values
      // and update together at the clock edge.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the output data register is reset as well; it is visible on the
      // port, and reset must drive the stream to a clean zero immediately.
      col_q      <= '0;
      row_q      <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit;
      data_out   <= emit_data;
      frame_done <= advance && last_pos;

      if (state_q == ST_IDLE) begin
        col_q <= '0;
        row_q <= '0;
      end else if (advance) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/upsample_pad_stream.md
UPSAMPLE_PAD_STREAM -- requirements
Module: upsample_pad_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed pixel width.
REQ-002 SHALL have parameter IN_WIDTH, default 14: input frame side length (square, raster order).
REQ-003 SHALL have parameters PAD_TOP, PAD_BOTTOM, PAD_LEFT, PAD_RIGHT, defaults 2, 3, 2, 3: zero rows and columns added around the upsampled grid.
REQ-004 SHALL derive OUT_WIDTH = 2*IN_WIDTH + PAD_LEFT + PAD_RIGHT and OUT_HEIGHT = 2*IN_WIDTH + PAD_TOP + PAD_BOTTOM (defaults 33, 33).
REQ-005 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port valid_in, input, 1: upstream pixel valid; upstream holds it until accepted.
REQ-008 Port data_in, input, DATA_WIDTH signed: upstream pixel.
REQ-009 Port ready_out, output, 1: block accepts data_in this cycle.
REQ-010 Port valid_out, output, 1: data_out holds an output pixel.
REQ-011 Port data_out, output, DATA_WIDTH signed: zero-inserted, padded pixel stream.
REQ-012 Port frame_done, output, 1: one-cycle pulse with the last output pixel of a frame.

Function
REQ-013 SHALL emit OUT_WIDTH x OUT_HEIGHT pixels per frame in raster order, one pixel per emitting cycle; downstream never stalls.
REQ-014 Output position (r,c) SHALL carry an input pixel iff u=r-PAD_TOP and v=c-PAD_LEFT satisfy: both are in 0..2*IN_WIDTH-1, and both are even. Such a position is a data position.
REQ-015 Data positions SHALL consume input pixels in raster order; input (u/2, v/2) maps to output (r,c). Every other position SHALL emit 0.
REQ-016 FSM SHALL have two states.
- IDLE: ready_out=0, valid_out=0. Moves to RUN when valid_in=1, with position counters at (0,0). No pixel is consumed on this transition.
- RUN: processes the current position each cycle (REQ-017, REQ-018).
REQ-017 In RUN at a data position, ready_out SHALL be 1 combinationally, decoded from state and counters only, never from valid_in.
- If valid_in=1: accept data_in, register it to data_out with valid_out=1, advance the position.
- If valid_in=0: valid_out=0 and the position holds.
REQ-018 In RUN at a zero position, ready_out SHALL be 0; the block registers data_out=0, valid_out=1 and advances the position.
REQ-019 Output latency SHALL be one cycle: pixel for the position processed in cycle N appears on data_out/valid_out in cycle N+1.
REQ-020 Column counter SHALL wrap from OUT_WIDTH-1 to 0 and increment the row counter.
REQ-021 After the pixel at (OUT_HEIGHT-1, OUT_WIDTH-1), the FSM SHALL return to IDLE. frame_done SHALL be 1 in the same cycle that pixel's valid_out is 1.
REQ-022 The next frame SHALL start only through IDLE. A valid_in held high at frame end SHALL start the next frame one cycle after frame_done.
REQ-023 Exactly IN_WIDTH*IN_WIDTH handshakes (valid_in & ready_out) SHALL occur per frame.
REQ-024 data_out SHALL pass input values unmodified, with no arithmetic or resizing.
REQ-025 With all PAD_* = 0, position (0,0) is a data position. It SHALL be accepted in the first RUN cycle when valid_in is still high.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, counters=0, valid_out=0, data_out=0, frame_done=0 and ready_out=0.
REQ-027 Reset mid-frame SHALL discard the partial frame. After release, the next frame starts at (0,0) on the next valid_in.

Structure
REQ-028 OUT_WIDTH, OUT_HEIGHT, state encodings and counter widths ($clog2 of OUT dims) SHALL live in a shared constants header included by this block and the trans-conv layers.
REQ-029 SHALL be a single module with no sub-modules; the position decode is inline combinational logic.

Verification
REQ-030 Setup: IN_WIDTH=2, all PAD_*=1 (6x6 out); inputs 1,2,3,4 with valid_in held high.
- Expect 36 valid_out pixels.
- Values 1,2,3,4 at output indices 7,9,19,21; all others 0.
- frame_done at index 35.
REQ-031 Same setup; valid_in deasserted 5 cycles before input 3.
- Emission pauses at index 19 with valid_out=0 for those cycles.
- Output content matches REQ-030.
REQ-032 Default parameters, 196 inputs 0x0001..0x00C4.
- Expect 1089 outputs.
- Input k appears at row 2+2*(k/14), column 2+2*(k%14).
- Exactly 196 handshakes.
REQ-033 Reset asserted at output index 15 of a frame.
- All outputs go to 0 immediately.
- The next full frame matches REQ-030.
REQ-034 All PAD_*=0, IN_WIDTH=2, inputs -5,7,-9,11.
- Output 4x4 is -5,0,7,0 / 0,0,0,0 / -9,0,11,0 / 0,0,0,0.
- Sign is preserved.
REQ-035 Back-to-back frames with valid_in never dropped: the second frame's first output appears 2 cycles after frame_done.
